// File: rtl/obuft_drv.sv
// rtl/obuft_drv.sv - half-duplex frame serializer driving a tri-state buffer's I/T pins
//
// Ports:
//   C     in   clock, rising edge
//   R     in   synchronous active-high reset
//   DIN   in   [WIDTH] byte to enqueue
//   WR    in   enqueue strobe (accepted when not FULL, or when a pop frees a slot)
//   FULL  out  FIFO holds DEPTH entries
//   BUSY  out  frame engine not idle or FIFO non-empty
//   DONE  out  one-cycle pulse while the stop bit is on the line
//   TO_I  out  buffer data pin
//   TO_T  out  buffer tri-state pin, 1 = released (high-Z)
//
// Optional feature macro: OBUFT_DRV_PARITY_EN (even parity bit between data and stop).

module obuft_drv #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int TURN  = 2
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] DIN,
    input  logic             WR,
    output logic             FULL,
    output logic             BUSY,
    output logic             DONE,
    output logic             TO_I,
    output logic             TO_T
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TW = (TURN > 1) ? $clog2(TURN) : 1;

`ifdef OBUFT_DRV_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, GAP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
`endif

    state_t state, state_nxt;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [WIDTH-1:0] shift;
    logic [BW-1:0]    bit_cnt;
    logic [TW-1:0]    turn_cnt;
    logic             fifo_empty, fifo_full, pop, push;
    logic             to_t_c, to_i_c, done_c;
`ifdef OBUFT_DRV_PARITY_EN
    logic             parity;
`endif

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = (state == IDLE) && !fifo_empty;
    // A pop on the same edge frees a slot, so a write into a full FIFO is still taken.
    assign push       = WR && (!fifo_full || pop);
    assign wr_ptr_nxt = wr_ptr + (AW+1)'(push);
    assign rd_ptr_nxt = rd_ptr + (AW+1)'(pop);

    always_ff @(posedge C) begin
        if (R) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Line levels are decoded from the current state and registered below, so
    // TO_T and TO_I always change together on one edge.
    always_comb begin
        state_nxt = state;
        to_t_c    = 1'b1;
        to_i_c    = 1'b1;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_nxt = START;
            end
            START: begin
                to_t_c    = 1'b0;
                to_i_c    = 1'b0;
                state_nxt = DATA;
            end
            DATA: begin
                to_t_c = 1'b0;
                to_i_c = shift[0];
                if (bit_cnt == BW'(WIDTH-1)) begin
`ifdef OBUFT_DRV_PARITY_EN
                    state_nxt = PAR;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef OBUFT_DRV_PARITY_EN
            PAR: begin
                to_t_c    = 1'b0;
                to_i_c    = parity;
                state_nxt = STOP;
            end
`endif
            STOP: begin
                to_t_c    = 1'b0;
                to_i_c    = 1'b1;
                done_c    = 1'b1;
                state_nxt = GAP;
            end
            GAP: begin
                if (turn_cnt == TW'(TURN-1)) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (!R && push) begin
            mem[wr_ptr[AW-1:0]] <= DIN;
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            shift    <= '0;
            bit_cnt  <= '0;
            turn_cnt <= '0;
            FULL     <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            TO_I     <= 1'b1;
            TO_T     <= 1'b1;
`ifdef OBUFT_DRV_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            if (pop) begin
                shift <= mem[rd_ptr[AW-1:0]];
`ifdef OBUFT_DRV_PARITY_EN
                parity <= ^mem[rd_ptr[AW-1:0]];
`endif
            end else if (state == DATA) begin
                shift <= shift >> 1;
            end
            bit_cnt  <= (state == DATA) ? bit_cnt + BW'(1) : '0;
            turn_cnt <= (state == GAP) ? turn_cnt + TW'(1) : '0;
            // FULL/BUSY reflect the post-edge FIFO and state so they track WR immediately.
            FULL <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                    (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
            BUSY <= (state_nxt != IDLE) || (wr_ptr_nxt != rd_ptr_nxt);
            DONE <= done_c;
            TO_I <= to_i_c;
            TO_T <= to_t_c;
        end
    end

endmodule

// File: tb/tb_obuft_drv.sv
// tb/tb_obuft_drv.sv - randomized self-checking bench for obuft_drv (TURN=2 and TURN=4 instances)

module tb_obuft_drv;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int TURNS [2] = '{2, 4};

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] wr;
    logic [7:0] din [2];
    logic [1:0] full, busy, done, to_i, to_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: a FIFO of bytes and a schedule of future line values {t,i,done}.
    bit [7:0] fq [2][$];
    bit [2:0] wq [2][$];
    bit       exp_t [2], exp_i [2], exp_d [2], exp_full [2], exp_busy [2];
    int       acc_cnt [2], done_cnt [2], t1_run [2], gap_len [2];
    bit       seen_frame [2];
    logic [31:0] cap0;
    int       cap_n;

    always #5 clk = ~clk;

    obuft_drv #(.WIDTH(W), .DEPTH(DEPTH), .TURN(2)) dut0 (
        .C(clk), .R(rst), .DIN(din[0]), .WR(wr[0]), .FULL(full[0]), .BUSY(busy[0]),
        .DONE(done[0]), .TO_I(to_i[0]), .TO_T(to_t[0])
    );

    obuft_drv #(.WIDTH(W), .DEPTH(DEPTH), .TURN(4)) dut1 (
        .C(clk), .R(rst), .DIN(din[1]), .WR(wr[1]), .FULL(full[1]), .BUSY(busy[1]),
        .DONE(done[1]), .TO_I(to_i[1]), .TO_T(to_t[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int i, input bit [7:0] b);
        wq[i].push_back(3'b000);
        for (int j = 0; j < W; j++) wq[i].push_back({1'b0, b[j], 1'b0});
`ifdef OBUFT_DRV_PARITY_EN
        wq[i].push_back({1'b0, ^b, 1'b0});
`endif
        wq[i].push_back(3'b011);
        for (int j = 0; j < TURNS[i]; j++) wq[i].push_back(3'b110);
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit       pop, acc;
            bit [2:0] e;
            bit [7:0] b;
            if (rst) begin
                fq[i].delete();
                wq[i].delete();
                e = 3'b110;
            end else begin
                // A new frame starts only once the previous frame and its gap are off the line.
                pop = (wq[i].size() == 0) && (fq[i].size() > 0);
                e   = (wq[i].size() > 0) ? wq[i].pop_front() : 3'b110;
                acc = wr[i] && ((fq[i].size() < DEPTH) || pop);
                if (pop) begin
                    b = fq[i].pop_front();
                    push_frame(i, b);
                end
                if (acc) begin
                    fq[i].push_back(din[i]);
                    acc_cnt[i]++;
                end
            end
            exp_t[i]    = e[2];
            exp_i[i]    = e[1];
            exp_d[i]    = e[0];
            exp_full[i] = (fq[i].size() == DEPTH);
            exp_busy[i] = (wq[i].size() > 0) || (fq[i].size() > 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("to_t%0d", i), to_t[i], exp_t[i]);
            check_eq($sformatf("to_i%0d", i), to_i[i], exp_i[i]);
            check_eq($sformatf("done%0d", i), done[i], exp_d[i]);
            check_eq($sformatf("full%0d", i), full[i], exp_full[i]);
            check_eq($sformatf("busy%0d", i), busy[i], exp_busy[i]);
            if (done[i]) done_cnt[i]++;
            if (to_t[i]) begin
                t1_run[i]++;
            end else begin
                if (seen_frame[i] && t1_run[i] > 0) gap_len[i] = t1_run[i];
                t1_run[i]     = 0;
                seen_frame[i] = 1'b1;
            end
        end
        if (!to_t[0]) begin
            cap0 = {cap0[30:0], to_i[0]};
            cap_n++;
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            acc_cnt[i]    = 0;
            done_cnt[i]   = 0;
            t1_run[i]     = 0;
            gap_len[i]    = 0;
            seen_frame[i] = 1'b0;
        end
        cap0  = '0;
        cap_n = 0;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 400; n++) begin
            if (busy == 2'b00 && wq[0].size() == 0 && wq[1].size() == 0) break;
            tick();
        end
        tick();
        check_eq({tag, "_busy"}, busy, 2'b00);
        check_eq({tag, "_to_t"}, to_t, 2'b11);
    endtask

    initial begin
        rst = 1'b1;
        wr  = 2'b00;
        din[0] = '0;
        din[1] = '0;
        clear_stats();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // single byte 0xA5
        clear_stats();
        wr = 2'b11;
        din[0] = 8'hA5;
        din[1] = 8'hA5;
        tick();
        wr = 2'b00;
        drain("a5");
`ifdef OBUFT_DRV_PARITY_EN
        check_eq("a5_bits", cap0, 32'h295);
        check_eq("a5_len", cap_n, 11);
`else
        check_eq("a5_bits", cap0, 32'h14B);
        check_eq("a5_len", cap_n, 10);
`endif
        check_eq("a5_done", done_cnt[0], 1);

        // back-to-back writes past full: the write during the pop edge is taken, later ones drop
        clear_stats();
        wr = 2'b11;
        for (int j = 0; j < 7; j++) begin
            din[0] = 8'h10 + 8'(j);
            din[1] = 8'h10 + 8'(j);
            tick();
        end
        wr = 2'b00;
        drain("fill");
        check_eq("fill_frames0", done_cnt[0], 5);
        check_eq("fill_frames1", done_cnt[1], 5);
        check_eq("fill_gap0", gap_len[0], 3);
        check_eq("fill_gap1", gap_len[1], 5);

        // WR held through full periods so writes land on pop edges
        clear_stats();
        wr = 2'b11;
        for (int j = 0; j < 40; j++) begin
            din[0] = 8'($urandom);
            din[1] = 8'($urandom);
            tick();
        end
        wr = 2'b00;
        drain("simul");
        check_eq("simul_frames0", done_cnt[0], acc_cnt[0]);
        check_eq("simul_frames1", done_cnt[1], acc_cnt[1]);

        // reset held for 3 cycles in the middle of a frame abandons it
        clear_stats();
        wr = 2'b11;
        din[0] = 8'h3C;
        din[1] = 8'hC3;
        tick();
        wr = 2'b00;
        repeat (6) tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        clear_stats();
        repeat (20) tick();
        check_eq("rst_done", done_cnt[0] + done_cnt[1], 0);
        check_eq("rst_line", {to_t, to_i}, 4'hF);

        // random traffic with occasional resets
        clear_stats();
        for (int j = 0; j < 1500; j++) begin
            wr[0]  = ($urandom_range(0, 3) == 0);
            wr[1]  = ($urandom_range(0, 1) == 0);
            din[0] = 8'($urandom);
            din[1] = 8'($urandom);
            rst    = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        wr  = 2'b00;
        drain("rand");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
